// File: rtl/timer_tick_master.sv
// Tick-service master for an interval-timer slave: arms the timer interrupt, clears each
// timeout, optionally snapshots the slave counter, and counts serviced ticks.
module timer_tick_master #(
    parameter bit SNAP_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        irq,
    input  logic [15:0] readdata,
    output logic        chipselect,
    output logic        write_n,
    output logic [2:0]  address,
    output logic [15:0] writedata,
    output logic        tick_pulse,
    output logic [31:0] tick_count,
    output logic [31:0] snapshot,
    output logic        snapshot_valid,
    output logic        busy
);

    typedef enum logic [3:0] {
        StIdle,
        StInitCtrl,
        StWaitIrq,
        StClrStatus,
        StSnapWr,
        StRdL,
        StRdH,
        StCapture,
        StStopCtrl
    } state_e;

    localparam logic [2:0] AddrStatus  = 3'd0;
    localparam logic [2:0] AddrControl = 3'd1;
    localparam logic [2:0] AddrSnapL   = 3'd4;
    localparam logic [2:0] AddrSnapH   = 3'd5;

    state_e      state_q;
    logic        cs_q;
    logic        write_n_q;
    logic [2:0]  addr_q;
    logic [15:0] wdata_q;
    logic        tick_q;
    logic [31:0] count_q;
    logic [31:0] snap_q;
    logic        snap_valid_q;
    logic        busy_q;

    // Bus and status registers are loaded with the values for the state being entered,
    // so each access is presented for exactly the one cycle spent in its state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            cs_q         <= 1'b0;
            write_n_q    <= 1'b1;
            addr_q       <= 3'd0;
            wdata_q      <= 16'h0000;
            tick_q       <= 1'b0;
            count_q      <= 32'h0000_0000;
            snap_q       <= 32'h0000_0000;
            snap_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            cs_q      <= 1'b0;
            write_n_q <= 1'b1;
            addr_q    <= 3'd0;
            wdata_q   <= 16'h0000;
            tick_q    <= 1'b0;
            busy_q    <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (enable) begin
                        state_q   <= StInitCtrl;
                        cs_q      <= 1'b1;
                        write_n_q <= 1'b0;
                        addr_q    <= AddrControl;
                        wdata_q   <= 16'h0001;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                StInitCtrl: begin
                    state_q <= StWaitIrq;
                    busy_q  <= 1'b0;
                end
                StWaitIrq: begin
                    if (irq) begin
                        state_q   <= StClrStatus;
                        cs_q      <= 1'b1;
                        write_n_q <= 1'b0;
                        addr_q    <= AddrStatus;
                    end else if (!enable) begin
                        state_q   <= StStopCtrl;
                        cs_q      <= 1'b1;
                        write_n_q <= 1'b0;
                        addr_q    <= AddrControl;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                StClrStatus: begin
                    if (SNAP_EN) begin
                        state_q   <= StSnapWr;
                        cs_q      <= 1'b1;
                        write_n_q <= 1'b0;
                        addr_q    <= AddrSnapL;
                    end else begin
                        state_q <= StCapture;
                        tick_q  <= 1'b1;
                        count_q <= count_q + 32'd1;
                    end
                end
                StSnapWr: begin
                    state_q <= StRdL;
                    cs_q    <= 1'b1;
                    addr_q  <= AddrSnapL;
                end
                StRdL: begin
                    state_q <= StRdH;
                    cs_q    <= 1'b1;
                    addr_q  <= AddrSnapH;
                end
                StRdH: begin
                    // readdata now carries snap_l from the RD_L access
                    snap_q[15:0] <= readdata;
                    state_q      <= StCapture;
                    tick_q       <= 1'b1;
                    count_q      <= count_q + 32'd1;
                end
                StCapture: begin
                    if (SNAP_EN) begin
                        snap_q[31:16] <= readdata;
                        snap_valid_q  <= 1'b1;
                    end
                    state_q <= StWaitIrq;
                    busy_q  <= 1'b0;
                end
                StStopCtrl: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign chipselect     = cs_q;
    assign write_n        = write_n_q;
    assign address        = addr_q;
    assign writedata      = wdata_q;
    assign tick_pulse     = tick_q;
    assign tick_count     = count_q;
    assign snapshot       = snap_q;
    assign snapshot_valid = snap_valid_q;
    assign busy           = busy_q;

endmodule

// File: doc/timer_tick_master.md
TIMER_TICK_MASTER -- requirements
Module: timer_tick_master

Interface
REQ-001 The block SHALL have parameter SNAP_EN, default 1, meaning 1 = capture and read the counter snapshot on each tick and 0 = skip the snapshot states.
REQ-002 The block SHALL have port clk, input, 1 bit, meaning system clock; all logic is rising-edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-004 The block SHALL have port enable, input, 1 bit, meaning level request to run the tick service.
REQ-005 The block SHALL have port irq, input, 1 bit, meaning interrupt from the interval-timer slave.
REQ-006 The block SHALL have port readdata, input, 16 bits, meaning slave read data, registered in the slave (read latency 1).
REQ-007 The block SHALL have port chipselect, output, 1 bit, meaning slave select.
REQ-008 The block SHALL have port write_n, output, 1 bit, meaning active-low write strobe.
REQ-009 The block SHALL have port address, output, 3 bits, meaning slave register index (0 status, 1 control, 4 snap_l, 5 snap_h).
REQ-010 The block SHALL have port writedata, output, 16 bits, meaning slave write data.
REQ-011 The block SHALL have port tick_pulse, output, 1 bit, meaning one-cycle pulse per serviced timeout.
REQ-012 The block SHALL have port tick_count, output, 32 bits, meaning serviced timeouts since reset.
REQ-013 The block SHALL have port snapshot, output, 32 bits, meaning {snap_h, snap_l} from the last service.
REQ-014 The block SHALL have port snapshot_valid, output, 1 bit, meaning snapshot holds data from at least one service.
REQ-015 The block SHALL have port busy, output, 1 bit, meaning the FSM is not in IDLE or WAIT_IRQ.

Function
REQ-016 All outputs SHALL be registered; the slave has no waitrequest, so each bus access SHALL occupy exactly one cycle.
REQ-017 Bus idle state SHALL be chipselect=0, write_n=1, address=0, writedata=0 in every state without an access.
REQ-018 The FSM SHALL have states IDLE, INIT_CTRL, WAIT_IRQ, CLR_STATUS, SNAP_WR, RD_L, RD_H, CAPTURE, STOP_CTRL.
REQ-019 IDLE: if enable=1, the FSM SHALL go to INIT_CTRL; otherwise it stays in IDLE.
REQ-020 INIT_CTRL: the block SHALL write address 1 with writedata=0x0001 (interrupt enable), then go to WAIT_IRQ.
REQ-021 WAIT_IRQ: if irq=1, go to CLR_STATUS; else if enable=0, go to STOP_CTRL; irq SHALL take priority over enable=0.
REQ-022 CLR_STATUS: the block SHALL write address 0 with writedata=0x0000, then go to SNAP_WR if SNAP_EN=1, else to CAPTURE.
REQ-023 SNAP_WR: the block SHALL write address 4 with writedata=0x0000 (latches the slave snapshot), then go to RD_L.
REQ-024 RD_L: the block SHALL drive chipselect=1, write_n=1, address=4, then go to RD_H.
REQ-025 RD_H: the block SHALL drive chipselect=1, write_n=1, address=5, and latch readdata into snapshot[15:0].
REQ-026 CAPTURE: the block SHALL issue no bus access; if SNAP_EN=1, it SHALL latch readdata into snapshot[31:16] and set snapshot_valid=1.
REQ-027 CAPTURE: the block SHALL pulse tick_pulse for one cycle, increment tick_count, then go to WAIT_IRQ.
REQ-028 tick_count SHALL increment modulo 2^32 (0xFFFFFFFF -> 0x00000000) with no saturation or flag.
REQ-029 STOP_CTRL: the block SHALL write address 1 with writedata=0x0000, then go to IDLE.
REQ-030 enable changes outside IDLE and WAIT_IRQ SHALL NOT abort the sequence in progress; they SHALL be acted on at the next IDLE or WAIT_IRQ.
REQ-031 Service latency SHALL be 5 cycles from irq sampled high to tick_pulse (SNAP_EN=1) and 2 cycles (SNAP_EN=0).
REQ-032 irq still high when WAIT_IRQ is re-entered SHALL be serviced as a new tick; the slave clears irq one cycle after the status write, so this occurs only on a genuine new timeout.
REQ-033 snapshot and snapshot_valid SHALL hold their values through disable and re-enable; they change only in RD_H or CAPTURE.

Reset
REQ-034 On reset_n=0, asynchronously: FSM=IDLE, chipselect=0, write_n=1, address=0, writedata=0, tick_pulse=0, tick_count=0, snapshot=0, snapshot_valid=0, busy=0.
REQ-035 Reset asserted mid-sequence SHALL abandon the sequence with no further bus access; after release, the FSM SHALL restart from IDLE and re-write the control register.

Verification
REQ-036 Reset, then enable=1 -> one write to address 1 with data 0x0001 on the next cycle; FSM in WAIT_IRQ; busy=0.
REQ-037 With the slave model loaded with snapshot 0x4C4B3F, pulse irq -> writes to address 0 and then address 4, reads of address 4 and then address 5, then snapshot=0x004C4B3F, snapshot_valid=1, tick_pulse=1 five cycles after irq, tick_count=1.
REQ-038 SNAP_EN=0, irq -> status write only; tick_pulse two cycles after irq; snapshot=0 and snapshot_valid=0 unchanged.
REQ-039 Preload tick_count=0xFFFFFFFF via a forced state, service one irq -> tick_count=0x00000000.
REQ-040 In WAIT_IRQ, irq=1 and enable=0 in the same cycle -> full service first, then STOP_CTRL writes 0x0000 to address 1, then IDLE.
REQ-041 Assert reset_n=0 during RD_L -> bus goes idle immediately and all outputs reset; after release with enable=1 -> control write 0x0001 is reissued.
